// File: rtl/axi_write_slave.sv
// AXI3 write-channel responder: takes one AW burst, streams its W beats onto a
// byte-strobed single-port memory write interface, then returns the B response.
module axi_write_slave #(
    parameter int buswidth = 32,
    parameter int tagbits  = 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [tagbits:0]         AWID,
    input  logic [buswidth-1:0]      AWADDR,
    input  logic [3:0]               AWLEN,
    input  logic [1:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic [1:0]               AWLOCK,
    input  logic [3:0]               AWCACHE,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [tagbits:0]         WID,
    input  logic [buswidth-1:0]      WDATA,
    input  logic [buswidth/8-1:0]    WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [tagbits:0]         BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [buswidth-1:0]      address_out,
    output logic [buswidth-1:0]      data_out,
    output logic [buswidth/8-1:0]    strobe_out,
    output logic                     memwrite
);

    localparam int nbytes   = buswidth / 8;
    localparam int lanebits = (nbytes > 1) ? $clog2(nbytes) : 1;
    localparam int maskbits = 2 * nbytes;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_BRESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [tagbits:0]        awid_r;
    logic [buswidth-1:0]     addr_r;
    logic [3:0]              len_r;
    logic [1:0]              size_r;
    logic [1:0]              burst_r;
    logic [8:0]              attr_r;
    logic [3:0]              cnt_r;
    logic                    err_r;
    logic                    beat_s;
    logic                    last_idx_s;
    logic                    beat_err_s;
    logic                    unused_attr_s;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // Byte lanes covered by one beat of the given size at the given address
    function automatic logic [nbytes-1:0] lane_mask(input logic [buswidth-1:0] addr,
                                                    input logic [1:0] size);
        logic [lanebits-1:0] size_mask;
        logic [lanebits-1:0] offset;
        logic [maskbits-1:0] span;
        size_mask = lanebits'((32'd1 << size) - 32'd1);
        offset    = addr[lanebits-1:0] & ~size_mask;
        span      = maskbits'((32'd1 << (32'd1 << size)) - 32'd1) << offset;
        return span[nbytes-1:0];
    endfunction

    // Address of the beat following the one at addr
    function automatic logic [buswidth-1:0] next_addr(input logic [buswidth-1:0] addr,
                                                      input logic [1:0] size,
                                                      input logic [3:0] len,
                                                      input logic [1:0] burst);
        logic [buswidth-1:0] step;
        logic [buswidth-1:0] incr;
        logic [buswidth-1:0] wrap_mask;
        step      = {{(buswidth-1){1'b0}}, 1'b1} << size;
        incr      = (addr & ~(step - {{(buswidth-1){1'b0}}, 1'b1})) + step;
        wrap_mask = (({{(buswidth-4){1'b0}}, len} + {{(buswidth-1){1'b0}}, 1'b1}) << size)
                    - {{(buswidth-1){1'b0}}, 1'b1};
        case (burst)
            2'b00:   return addr;
            2'b10:   return wrap_len_ok(len) ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
            default: return incr;
        endcase
    endfunction

    // Lock/cache/prot are kept with the burst but never influence behaviour
    assign unused_attr_s = ^attr_r;

    // State register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and channel handshakes
    always_comb begin
        next_state_s = state_r;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    next_state_s = ST_WDATA;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                WREADY = 1'b1;
                if (WVALID && last_idx_s) begin
                    next_state_s = ST_BRESP;
                end else begin
                    next_state_s = ST_WDATA;
                end
            end
            ST_BRESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BRESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs follow the accepted beat within the same cycle
    always_comb begin
        last_idx_s  = (cnt_r == len_r);
        beat_s      = (state_r == ST_WDATA) && WVALID;
        beat_err_s  = (WLAST != last_idx_s) || (WID != awid_r);
        memwrite    = beat_s && (burst_r != 2'b11);
        address_out = {buswidth{1'b0}};
        data_out    = {buswidth{1'b0}};
        strobe_out  = {nbytes{1'b0}};
        BID         = {(tagbits+1){1'b0}};
        BRESP       = 2'b00;
        if (state_r == ST_WDATA) begin
            address_out = addr_r;
        end else begin
            address_out = {buswidth{1'b0}};
        end
        if (beat_s) begin
            data_out = WDATA;
        end else begin
            data_out = {buswidth{1'b0}};
        end
        if (memwrite) begin
            strobe_out = WSTRB & lane_mask(addr_r, size_r);
        end else begin
            strobe_out = {nbytes{1'b0}};
        end
        if (state_r == ST_BRESP) begin
            BID   = awid_r;
            BRESP = err_r ? 2'b10 : 2'b00;
        end else begin
            BID   = {(tagbits+1){1'b0}};
            BRESP = 2'b00;
        end
    end

    // Burst context: captured on AW, advanced on every accepted beat
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            awid_r  <= {(tagbits+1){1'b0}};
            addr_r  <= {buswidth{1'b0}};
            len_r   <= 4'd0;
            size_r  <= 2'd0;
            burst_r <= 2'd0;
            attr_r  <= 9'd0;
            cnt_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (AWVALID) begin
                        awid_r  <= AWID;
                        addr_r  <= AWADDR;
                        len_r   <= AWLEN;
                        size_r  <= AWSIZE;
                        burst_r <= AWBURST;
                        attr_r  <= {AWLOCK, AWCACHE, AWPROT};
                        cnt_r   <= 4'd0;
                        err_r   <= (AWBURST == 2'b11) ||
                                   ((AWBURST == 2'b10) && !wrap_len_ok(AWLEN));
                    end
                end
                ST_WDATA: begin
                    if (WVALID) begin
                        addr_r <= next_addr(addr_r, size_r, len_r, burst_r);
                        cnt_r  <= cnt_r + 4'd1;
                        if (beat_err_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Scoreboard bench for axi_write_slave: expected memory writes and B responses
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_axi_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [1:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [1:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [1:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] address_out;
    logic [31:0] data_out;
    logic [3:0]  strobe_out;
    logic        memwrite;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } mw_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_t;

    mw_t mw_q[$];
    b_t  b_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 ACLK = ~ACLK;

    axi_write_slave #(.buswidth(32), .tagbits(1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .address_out(address_out), .data_out(data_out), .strobe_out(strobe_out),
        .memwrite(memwrite)
    );

    task automatic check_val(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
        vectors++;
        if (obsv !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obsv, expv, $time);
        end
    endtask

    // Lanes touched by a beat: size-aligned offset inside the word, 1<<size bytes wide
    function automatic logic [3:0] exp_strb(input logic [31:0] a, input int size);
        int bytes;
        int off;
        logic [3:0] m;
        bytes = 1 << size;
        off   = ((a % 4) / bytes) * bytes;
        m     = 4'h0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + bytes) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Reference address sequencing: modular arithmetic on the wrap block
    function automatic logic [31:0] exp_next(input logic [31:0] a, input int size,
                                             input int len, input logic [1:0] burst);
        logic [31:0] bytes;
        logic [31:0] al;
        logic [31:0] blk;
        logic [31:0] base;
        bytes = 32'd1 << size;
        al    = a - (a % bytes);
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            blk  = 32'(len + 1) * bytes;
            base = a - (a % blk);
            return base + ((al - base + bytes) % blk);
        end
        return al + bytes;
    endfunction

    // Scoreboard: pop and compare whenever the DUT writes memory or completes B
    always @(negedge ACLK) begin : monitor
        mw_t em;
        b_t  eb;
        if (ARESETn) begin
            if (memwrite) begin
                if (mw_q.size() == 0) begin
                    check_val("mw_unexpected", {32'd0, address_out}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    em = mw_q.pop_front();
                    check_val("mw_addr", 64'(address_out), 64'(em.addr));
                    check_val("mw_data", 64'(data_out), 64'(em.data));
                    check_val("mw_strb", 64'(strobe_out), 64'(em.strb));
                end
            end
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    check_val("b_unexpected", 64'(BID), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    eb = b_q.pop_front();
                    check_val("b_id", 64'(BID), 64'(eb.id));
                    check_val("b_resp", 64'(BRESP), 64'(eb.resp));
                end
            end
        end
    end

    task automatic do_aw(input logic [1:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 2'(size); AWBURST = burst;
        AWLOCK = 2'b01; AWCACHE = 4'h3; AWPROT = 3'h2;
        AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 20) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            n++;
        end
        check_val("aw_ready", 64'(AWREADY), 64'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic finish_b(input logic [1:0] id, input logic [1:0] resp, input int bdelay);
        int n;
        BREADY = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge ACLK);
            check_val("bhold_valid", 64'(BVALID), 64'd1);
            check_val("bhold_id", 64'(BID), 64'(id));
            check_val("bhold_resp", 64'(BRESP), 64'(resp));
            check_val("bhold_awready", 64'(AWREADY), 64'd0);
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 20) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            n++;
        end
        if (!BVALID) check_val("b_timeout", 64'd0, 64'd1);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        check_val("idle_awready", 64'(AWREADY), 64'd1);
        check_val("b_left", 64'(b_q.size()), 64'd0);
        @(posedge ACLK); #1;
    endtask

    // One complete burst; abort_after >= 0 pulls reset after that beat instead of finishing
    task automatic run_burst(input logic [1:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst, input logic [1:0] wid,
                             input int bad_last, input bit gaps, input int bdelay,
                             input int abort_after);
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        mw_t         m;
        b_t          eb;
        bit          err;
        err = (burst == 2'b11) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (wid != id) || (bad_last >= 0);
        do_aw(id, addr, len, size, burst);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (gaps && (i % 2 == 1)) begin
                WVALID = 1'b0;
                @(negedge ACLK);
                check_val("gap_memwrite", 64'(memwrite), 64'd0);
                @(posedge ACLK); #1;
            end
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            WID = wid; WDATA = d; WSTRB = s;
            WLAST = (i == len) || (i == bad_last);
            WVALID = 1'b1;
            if (burst != 2'b11) begin
                m.addr = a; m.data = d; m.strb = s & exp_strb(a, size);
                mw_q.push_back(m);
            end
            @(negedge ACLK);
            check_val("wready", 64'(WREADY), 64'd1);
            @(posedge ACLK); #1;
            a = exp_next(a, size, len, burst);
            if (i == abort_after) begin
                ARESETn = 1'b0;
                WVALID  = 1'b0;
                WLAST   = 1'b0;
                @(posedge ACLK); #1;
                @(negedge ACLK);
                check_val("abort_awready", 64'(AWREADY), 64'd1);
                check_val("abort_wready", 64'(WREADY), 64'd0);
                check_val("abort_bvalid", 64'(BVALID), 64'd0);
                check_val("abort_memwrite", 64'(memwrite), 64'd0);
                check_val("abort_mw_left", 64'(mw_q.size()), 64'd0);
                ARESETn = 1'b1;
                @(posedge ACLK); #1;
                return;
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check_val("mw_left", 64'(mw_q.size()), 64'd0);
        eb.id = id;
        eb.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(eb);
        finish_b(id, eb.resp, bdelay);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        ARESETn = 1'b0;
        AWID = 2'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 2'd0; AWBURST = 2'd0;
        AWLOCK = 2'd0; AWCACHE = 4'd0; AWPROT = 3'd0; AWVALID = 1'b0;
        WID = 2'd0; WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check_val("rst_awready", 64'(AWREADY), 64'd1);
        check_val("rst_wready", 64'(WREADY), 64'd0);
        check_val("rst_bvalid", 64'(BVALID), 64'd0);
        check_val("rst_memwrite", 64'(memwrite), 64'd0);
        check_val("rst_addr", 64'(address_out), 64'd0);
        check_val("rst_bid", 64'(BID), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // INCR word burst
        run_burst(2'd1, 32'h08, 2, 2, 2'b01, 2'd1, -1, 1'b0, 0, -1);
        // narrow INCR, byte lanes walk 2,4,8,1
        run_burst(2'd1, 32'h01, 3, 0, 2'b01, 2'd1, -1, 1'b0, 0, -1);
        // WRAP inside a 16-byte block, then FIXED
        run_burst(2'd0, 32'h18, 3, 2, 2'b10, 2'd0, -1, 1'b0, 0, -1);
        run_burst(2'd2, 32'h20, 1, 2, 2'b00, 2'd2, -1, 1'b0, 0, -1);
        // narrow halfword WRAP inside an 8-byte block
        run_burst(2'd3, 32'h06, 3, 1, 2'b10, 2'd3, -1, 1'b0, 1, -1);
        // early WLAST, WID mismatch, reserved burst, illegal WRAP length
        run_burst(2'd1, 32'h100, 3, 2, 2'b01, 2'd1, 1, 1'b0, 0, -1);
        run_burst(2'd2, 32'h200, 1, 2, 2'b01, 2'd1, -1, 1'b0, 0, -1);
        run_burst(2'd3, 32'h300, 2, 2, 2'b11, 2'd3, -1, 1'b0, 0, -1);
        run_burst(2'd1, 32'h34, 2, 2, 2'b10, 2'd1, -1, 1'b0, 0, -1);
        // a clean burst right after an errored one must be OKAY again
        run_burst(2'd0, 32'h400, 0, 2, 2'b01, 2'd0, -1, 1'b0, 0, -1);
        // WVALID gaps and BREADY held low
        run_burst(2'd1, 32'h50, 3, 2, 2'b01, 2'd1, -1, 1'b1, 5, -1);
        // reset mid-burst, then a fresh burst
        run_burst(2'd1, 32'h60, 3, 2, 2'b01, 2'd1, -1, 1'b0, 0, 1);
        run_burst(2'd2, 32'h70, 1, 2, 2'b01, 2'd2, -1, 1'b0, 0, -1);
        // address wrap past the top of the space
        run_burst(2'd1, 32'hFFFF_FFF8, 3, 2, 2'b01, 2'd1, -1, 1'b0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
